pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 34 +++
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall handshake between the pipeline datapath and its controller.
// The datapath side raises hazard requests; the controller side returns
// stage enables, bubble flushes and the divider launch pulse.
interface pipeline_ctrl_if;
  logic load_hazard;
  logic is_jump;
  logic div_start;
  logic div_done;
  logic dmem_req;
  logic dmem_ready;
  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic div_go;

  // datapath side: raises requests, consumes enables
  modport master (
    output load_hazard, is_jump, div_start, div_done, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush, div_go
  );

  // controller side
  modport slave (
    input  load_hazard, is_jump, div_start, div_done, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush, div_go
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller. RUN resolves hazards by priority
// (memory wait > divide > load-use > jump); DIV_WAIT and MEM_WAIT hold the
// pipe until the unit finishes or the wait counter forces a release.
// Stage controls are combinational; state and counters are registered.
module pipeline_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high synchronous reset
  pipeline_ctrl_if.slave   pif,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // bundled stage controls, MSB first
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
    logic if_id_f;
    logic id_ex_f;
    logic ex_mem_f;
    logic div_go;
  } ctl_t;

  localparam ctl_t CTL_NONE     = ctl_t'(9'b00000_000_0);
  localparam ctl_t CTL_FULL     = ctl_t'(9'b11111_000_0);
  localparam ctl_t CTL_DIV_GO   = ctl_t'(9'b00001_001_1);
  localparam ctl_t CTL_DIV_HOLD = ctl_t'(9'b00001_001_0);
  localparam ctl_t CTL_LOAD     = ctl_t'(9'b00111_010_0);
  localparam ctl_t CTL_JUMP     = ctl_t'(9'b11111_110_0);

  // counter only has to reach TIMEOUT-1
  localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              expire;
  ctl_t              ctl;
  logic              any_flush;

  // next state and stage controls; reset forces every control low
  always_comb begin
    ctl    = CTL_NONE;
    nxt    = cur;
    expire = 1'b0;
    if (rst_n) begin
      nxt = RUN;
    end else begin
      case (cur)
        RUN: begin
          if (pif.dmem_req && !pif.dmem_ready) begin
            ctl = CTL_NONE;
            nxt = MEM_WAIT;
          end else if (pif.div_start) begin
            ctl = CTL_DIV_GO;
            nxt = DIV_WAIT;
          end else if (pif.load_hazard) begin
            ctl = CTL_LOAD;
          end else if (pif.is_jump) begin
            ctl = CTL_JUMP;
          end else begin
            ctl = CTL_FULL;
          end
        end
        DIV_WAIT: begin
          if (pif.div_done) begin
            ctl = CTL_FULL;
            nxt = RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            ctl    = CTL_FULL;
            nxt    = RUN;
            expire = 1'b1;
          end else begin
            ctl = CTL_DIV_HOLD;
          end
        end
        MEM_WAIT: begin
          if (pif.dmem_ready) begin
            ctl = CTL_FULL;
            nxt = RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            ctl    = CTL_FULL;
            nxt    = RUN;
            expire = 1'b1;
          end else begin
            ctl = CTL_NONE;
          end
        end
        default: nxt = RUN;
      endcase
    end
  end

  assign any_flush = ctl.if_id_f | ctl.id_ex_f | ctl.ex_mem_f;

  assign pif.pc_en        = ctl.pc;
  assign pif.if_id_en     = ctl.if_id;
  assign pif.id_ex_en     = ctl.id_ex;
  assign pif.ex_mem_en    = ctl.ex_mem;
  assign pif.mem_wb_en    = ctl.mem_wb;
  assign pif.if_id_flush  = ctl.if_id_f;
  assign pif.id_ex_flush  = ctl.id_ex_f;
  assign pif.ex_mem_flush = ctl.ex_mem_f;
  assign pif.div_go       = ctl.div_go;
  assign state            = cur;

  // state register; wait counter restarts on every entry to a wait state
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur      <= RUN;
      wait_cnt <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= (cur != RUN && nxt == cur) ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  // sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst_n)       timeout_err <= 1'b0;
    else if (expire) timeout_err <= 1'b1;
  end

  // saturating stall/flush performance counters
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctl.pc && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (any_flush && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
